// File: rtl/drain_pkg.sv
// drain_pkg
// Shared definitions for the store drain slice:
//   state_t        - drain FSM states (WAIT, DRAIN)
//   N_DEFAULT      - default volume loaded on each fill
//   CBITS_DEFAULT  - default width of the level counter
//   cfg_ok()       - elaboration-time sanity check of an (N, CBITS) pair
package drain_pkg;

  typedef enum logic {
    WAIT  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int N_DEFAULT     = 25000;
  localparam int CBITS_DEFAULT = 15;

  // The volume must be at least one unit and must fit in the level counter.
  function automatic bit cfg_ok(input int n, input int cbits);
    return (n >= 1) && (longint'(n) < (longint'(1) << cbits));
  endfunction

endpackage

// File: rtl/store_drain_if.sv
// store_drain_if
// Bundles the fill indication, the unit-token handshake and the status
// outputs of store_drain.
//   full_in   - loader reports the store holds N units
//   out_valid - a unit token is offered to the sink
//   out_ready - the sink accepts a unit this cycle
//   level     - units still to drain
//   empty     - nothing loaded and no drain in progress
//   done      - one-cycle pulse on the last transfer of a fill
// Modports: master = store_drain side, slave = loader/sink side.
interface store_drain_if #(
  parameter int CBITS = drain_pkg::CBITS_DEFAULT
);

  logic             full_in;
  logic             out_valid;
  logic             out_ready;
  logic [CBITS-1:0] level;
  logic             empty;
  logic             done;

  modport master (
    input  full_in,
    input  out_ready,
    output out_valid,
    output level,
    output empty,
    output done
  );

  modport slave (
    output full_in,
    output out_ready,
    input  out_valid,
    input  level,
    input  empty,
    input  done
  );

endinterface

// File: rtl/sat_down_counter.sv
// sat_down_counter
// Loadable down counter that saturates at zero.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val this cycle (wins over dec)
//   load_val  - value to load
//   dec       - decrement by one; ignored when the count is already 0
//   count     - current count
//   is_one    - count equals 1 (next decrement is the final one)
module sat_down_counter #(
  parameter int CBITS = drain_pkg::CBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CBITS-1:0] load_val,
  input  logic             dec,
  output logic [CBITS-1:0] count,
  output logic             is_one
);

  logic [CBITS-1:0] count_q;
  logic [CBITS-1:0] count_d;

  // Load has priority; a decrement at zero holds so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == CBITS'(1));

endmodule

// File: rtl/store_drain.sv
// store_drain
// Consumer side of the load/store tank. On a full indication it loads its
// level to N and hands out N unit tokens over a valid/ready handshake,
// pulsing done on the last one. A full indication seen while draining is
// remembered (at most one) and reloads the level without a bubble.
//   clk  - single clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - store_drain_if master modport (full_in, out_ready in;
//          out_valid, level, empty, done out)
module store_drain
  import drain_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CBITS = CBITS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  store_drain_if.master bus
);

  localparam logic [CBITS-1:0] LOAD_VAL = CBITS'(N);

  if (!cfg_ok(N, CBITS)) begin : g_bad_cfg
    $error("store_drain: N must satisfy 1 <= N < 2**CBITS");
  end

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             load;
  logic             dec;
  logic             transfer;
  logic             is_one;
  logic [CBITS-1:0] count;

  sat_down_counter #(
    .CBITS (CBITS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (LOAD_VAL),
    .dec      (dec),
    .count    (count),
    .is_one   (is_one)
  );

  assign transfer = (state_q == DRAIN) && bus.out_ready;

  // Next state, pending flag and counter control. On the final transfer a
  // pending fill, or one arriving in that same cycle, reloads straight away
  // so out_valid never drops between back-to-back fills.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    load      = 1'b0;
    dec       = 1'b0;
    case (state_q)
      WAIT: begin
        if (bus.full_in) begin
          state_d = DRAIN;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        if (transfer && is_one) begin
          done_d = 1'b1;
          if (pending_q || bus.full_in) begin
            load      = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d = WAIT;
            dec     = 1'b1;
          end
        end else begin
          dec = transfer;
          if (bus.full_in) begin
            pending_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign bus.out_valid = (state_q == DRAIN);
  assign bus.empty     = (state_q == WAIT);
  assign bus.level     = count;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_store_drain.sv
// tb_store_drain
// Directed bench for store_drain: a small instance (N=4, CBITS=3) exercises
// handshake stalls, pending reloads and reset, and a default instance
// (N=25000, CBITS=15) checks the full drain length.
module tb_store_drain;
   import drain_pkg::*;

   localparam int SN     = 4;
   localparam int SCBITS = 3;
   localparam int BN     = N_DEFAULT;
   localparam int BCBITS = CBITS_DEFAULT;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   store_drain_if #(.CBITS(SCBITS)) s_if ();
   store_drain_if #(.CBITS(BCBITS)) b_if ();

   store_drain #(
      .N     (SN),
      .CBITS (SCBITS)
   ) dut_small (
      .clk (clk),
      .rst (rst),
      .bus (s_if.master)
   );

   store_drain #(
      .N     (BN),
      .CBITS (BCBITS)
   ) dut_big (
      .clk (clk),
      .rst (rst),
      .bus (b_if.master)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives reset and the small instance's inputs, then advances one edge
   // and settles so outputs are sampled away from the clock edge.
   task automatic applyStimulus(input logic r, input logic f, input logic rd);
      rst         = r;
      s_if.full_in   = f;
      s_if.out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkSmall(input string tag, input int v, input int l,
                             input int e, input int d);
      checkOutput({tag, "_valid"}, int'(s_if.out_valid), v);
      checkOutput({tag, "_level"}, int'(s_if.level), l);
      checkOutput({tag, "_empty"}, int'(s_if.empty), e);
      checkOutput({tag, "_done"},  int'(s_if.done), d);
   endtask

   // Linear sequence of directed steps.
   initial begin
      int   expLvl;
      int   expDone;
      int   doneSeen;
      int   earlyDone;
      logic r;

      checks   = 0;
      failures = 0;
      b_if.full_in   = 1'b0;
      b_if.out_ready = 1'b0;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkSmall("reset", 0, 0, 1, 0);
      checkOutput("big_reset_empty", int'(b_if.empty), 1);
      checkOutput("big_reset_level", int'(b_if.level), 0);

      // Basic fill and drain with out_ready high
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("fill", 1, 4, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("drain3", 1, 3, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("drain1", 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("drain_last", 0, 0, 1, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("wait_idle", 0, 0, 1, 0);

      // out_ready toggling 1,0,0,1,... against a small level model
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkSmall("tog_fill", 1, 4, 0, 0);
      expLvl   = SN;
      doneSeen = 0;
      for (int i = 0; i < 20 && doneSeen == 0; i++) begin
         r = (i % 3 == 0);
         applyStimulus(1'b0, 1'b0, r);
         expDone = 0;
         if (r) begin
            if (expLvl == 1) begin
               expLvl   = 0;
               expDone  = 1;
               doneSeen = 1;
            end else begin
               expLvl--;
            end
         end
         checkSmall($sformatf("tog%0d", i), (expLvl != 0) ? 1 : 0, expLvl,
                    (expLvl == 0) ? 1 : 0, expDone);
      end

      // Pending fill raised at level 3: no bubble, two done pulses
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("pend_fill", 1, 4, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_l3", 1, 3, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("pend_set", 1, 2, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_l1", 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_reload", 1, 4, 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_l3b", 1, 3, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_l1b", 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("pend_empty", 0, 0, 1, 1);

      // full_in together with the final transfer reloads immediately
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkSmall("same_fill", 1, 4, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("same_l1", 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("same_reload", 1, 4, 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkSmall("same_stall", 1, 4, 0, 0);

      // Reset at level 2 with pending set discards everything
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("rst_l3", 1, 3, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("rst_l2", 1, 2, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkSmall("rst_mid", 0, 0, 1, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("rst_after", 0, 0, 1, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkSmall("rst_fresh", 1, 4, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("rst_fresh_end", 0, 0, 1, 1);

      // full_in together with reset must not load
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkSmall("rst_full", 0, 0, 1, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkSmall("rst_full_after", 0, 0, 1, 0);

      // Default-size instance: done exactly N cycles after out_valid rises
      b_if.full_in   = 1'b1;
      b_if.out_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      b_if.full_in = 1'b0;
      checkOutput("big_fill_valid", int'(b_if.out_valid), 1);
      checkOutput("big_fill_level", int'(b_if.level), BN);
      earlyDone = 0;
      for (int i = 1; i < BN; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (b_if.done !== 1'b0 || b_if.out_valid !== 1'b1) begin
            earlyDone = 1;
         end
      end
      checkOutput("big_no_early_done", earlyDone, 0);
      checkOutput("big_level_before_last", int'(b_if.level), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("big_done", int'(b_if.done), 1);
      checkOutput("big_level_end", int'(b_if.level), 0);
      checkOutput("big_empty_end", int'(b_if.empty), 1);
      checkOutput("big_valid_end", int'(b_if.out_valid), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("big_done_pulse", int'(b_if.done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
